// File: rtl/mlp_argmax_collector.sv
// mlp_argmax_collector
// Snoops the MLP output-buffer write port, captures one image's FP32 logits,
// then walks them one per cycle to find the IEEE-754 argmax. The result is
// presented on a valid/ready interface, with a done pulse on the handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start_i; snooped writes ignored silently
// S_COLLECT | capturing logits into the score array / valid mask
// S_COMPARE | scanning one score entry per cycle, tracking the best key
// S_HOLD    | result presented until the consumer accepts it
module mlp_argmax_collector #(
  parameter int NUM_CLASS   = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int ADDR_STRIDE = 4,
  parameter int CLS_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  prcss_done_i,
  input  logic                  y_buf_en_i,
  input  logic                  y_buf_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] y_buf_addr_i,
  input  logic [DATA_WIDTH-1:0] y_buf_data_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [CLS_WIDTH-1:0]  class_o,
  output logic [DATA_WIDTH-1:0] max_score_o,
  output logic [3:0]            err_o,
  output logic                  done_o
);

  localparam int SHIFT = $clog2(ADDR_STRIDE);
  localparam int IDX_W = ADDR_WIDTH - SHIFT;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMPARE, S_HOLD} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  score [NUM_CLASS];
  logic [NUM_CLASS-1:0]   mask;
  logic [CLS_WIDTH-1:0]   cmp_idx;
  logic                   best_found;
  logic [CLS_WIDTH-1:0]   best_idx;
  logic [DATA_WIDTH-1:0]  best_val;

  logic                   wr_hit;
  logic [IDX_W-1:0]       wr_idx;
  logic                   wr_addr_ok;
  logic [NUM_CLASS-1:0]   wr_onehot;
  logic [NUM_CLASS-1:0]   mask_next;
  logic [DATA_WIDTH-1:0]  cur_val;
  logic                   cur_nan;
  logic                   cur_skip;
  logic                   cur_take;
  logic                   nxt_found;
  logic [CLS_WIDTH-1:0]   nxt_idx;
  logic [DATA_WIDTH-1:0]  nxt_val;

  // Map an FP32 pattern onto an unsigned key that orders like the float value
  // (negatives inverted, positives with the sign bit flipped up).
  function automatic logic [DATA_WIDTH-1:0] ord_key(input logic [DATA_WIDTH-1:0] x);
    if (x[DATA_WIDTH-1])
      return ~x;
    else
      return {1'b1, x[DATA_WIDTH-2:0]};
  endfunction

  // Capture decode and mask including the write in flight.
  always_comb begin
    wr_hit     = y_buf_en_i & y_buf_wr_en_i;
    wr_idx     = y_buf_addr_i[ADDR_WIDTH-1:SHIFT];
    wr_addr_ok = (y_buf_addr_i[SHIFT-1:0] == '0) && (32'(wr_idx) < NUM_CLASS);
    wr_onehot  = '0;
    if (wr_addr_ok)
      wr_onehot[wr_idx] = 1'b1;
    mask_next  = mask | (wr_hit ? wr_onehot : '0);
  end

  // One compare step: decide whether entry cmp_idx replaces the current best.
  always_comb begin
    cur_val   = score[cmp_idx];
    cur_nan   = (cur_val[30:23] == 8'hFF) && (cur_val[22:0] != '0);
    cur_skip  = ~mask[cmp_idx] | cur_nan;
    cur_take  = ~cur_skip & (~best_found | (ord_key(cur_val) > ord_key(best_val)));
    nxt_found = best_found | cur_take;
    nxt_idx   = cur_take ? cmp_idx : best_idx;
    nxt_val   = cur_take ? cur_val : best_val;
  end

  // Control FSM, capture storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      for (int k = 0; k < NUM_CLASS; k++) score[k] <= '0;
      mask           <= '0;
      cmp_idx        <= '0;
      best_found     <= 1'b0;
      best_idx       <= '0;
      best_val       <= '0;
      result_valid_o <= 1'b0;
      class_o        <= '0;
      max_score_o    <= '0;
      err_o          <= '0;
      done_o         <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        state          <= S_COLLECT;
        mask           <= '0;
        err_o          <= '0;
        class_o        <= '0;
        max_score_o    <= '0;
        result_valid_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_COLLECT: begin
            if (wr_hit) begin
              if (wr_addr_ok)
                score[wr_idx] <= y_buf_data_i;
              else
                err_o[0] <= 1'b1;
            end
            mask <= mask_next;
            if ((&mask_next) || prcss_done_i) begin
              // A full mask wins over a simultaneous done, so no incomplete flag then.
              if (!(&mask_next))
                err_o[2] <= 1'b1;
              state      <= S_COMPARE;
              cmp_idx    <= '0;
              best_found <= 1'b0;
              best_idx   <= '0;
              best_val   <= '0;
            end
          end
          S_COMPARE: begin
            if (wr_hit)
              err_o[3] <= 1'b1;
            if (mask[cmp_idx] && cur_nan)
              err_o[1] <= 1'b1;
            best_found <= nxt_found;
            best_idx   <= nxt_idx;
            best_val   <= nxt_val;
            if (cmp_idx == CLS_WIDTH'(NUM_CLASS - 1)) begin
              state          <= S_HOLD;
              result_valid_o <= 1'b1;
              class_o        <= nxt_found ? nxt_idx : '0;
              max_score_o    <= nxt_found ? nxt_val : '0;
              if (!nxt_found)
                err_o[2] <= 1'b1;
            end else begin
              cmp_idx <= cmp_idx + 1'b1;
            end
          end
          S_HOLD: begin
            if (wr_hit)
              err_o[3] <= 1'b1;
            if (result_ready_i) begin
              state          <= S_IDLE;
              result_valid_o <= 1'b0;
              done_o         <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mlp_argmax_collector.sv
// Directed bench for mlp_argmax_collector: table of whole-frame vectors plus
// hand-written sequences for reset, bad address/overrun and backpressure/abort.
module tb_mlp_argmax_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        prcss_done_i;
  logic        y_buf_en_i;
  logic        y_buf_wr_en_i;
  logic [5:0]  y_buf_addr_i;
  logic [31:0] y_buf_data_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [3:0]  class_o;
  logic [31:0] max_score_o;
  logic [3:0]  err_o;
  logic        done_o;

  mlp_argmax_collector dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .prcss_done_i   (prcss_done_i),
    .y_buf_en_i     (y_buf_en_i),
    .y_buf_wr_en_i  (y_buf_wr_en_i),
    .y_buf_addr_i   (y_buf_addr_i),
    .y_buf_data_i   (y_buf_data_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .class_o        (class_o),
    .max_score_o    (max_score_o),
    .err_o          (err_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0][31:0] v;
    logic [9:0]       wmask;
    logic [3:0]       cls;
    logic [31:0]      score;
    logic [3:0]       err;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vt [NVEC];
  logic [31:0] ten [10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                            32'h41100000, 32'h41200000};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    y_buf_en_i    = 1'b1;
    y_buf_wr_en_i = 1'b1;
    y_buf_addr_i  = a;
    y_buf_data_i  = d;
    tick();
    y_buf_en_i    = 1'b0;
    y_buf_wr_en_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic write_vec(input vec_t t);
    for (int i = 0; i < 10; i++)
      if (t.wmask[i]) wr(6'(i * 4), t.v[i]);
  endtask

  // Called right after the edge that sampled the completing event.
  task automatic wait_valid(input string name);
    int lat;
    lat = 0;
    while (!result_valid_o && lat < 40) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd10);
  endtask

  task automatic handshake(input string name);
    result_ready_i = 1'b1;
    tick();
    chk({name, "_done_pulse"}, {31'd0, done_o}, 32'd1);
    chk({name, "_valid_drop"}, {31'd0, result_valid_o}, 32'd0);
    tick();
    chk({name, "_done_single"}, {31'd0, done_o}, 32'd0);
    result_ready_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stable;

    // Frame vectors: logits, write mask, expected class/score/err.
    for (int i = 0; i < 10; i++) vt[0].v[i] = ten[i];
    vt[0].wmask = 10'h3FF; vt[0].cls = 4'd9; vt[0].score = 32'h41200000; vt[0].err = 4'b0000;

    for (int i = 0; i < 10; i++) vt[1].v[i] = 32'hBF800000;
    vt[1].v[3] = 32'hBF000000; vt[1].v[7] = 32'hBF000000;
    vt[1].wmask = 10'h3FF; vt[1].cls = 4'd3; vt[1].score = 32'hBF000000; vt[1].err = 4'b0000;

    for (int i = 0; i < 10; i++) vt[2].v[i] = 32'hBF800000;
    vt[2].v[2] = 32'h00000000; vt[2].v[1] = 32'h80000000;
    vt[2].wmask = 10'h3FF; vt[2].cls = 4'd2; vt[2].score = 32'h00000000; vt[2].err = 4'b0000;

    for (int i = 0; i < 10; i++) vt[3].v[i] = 32'h0;
    vt[3].v[0] = 32'h3F800000; vt[3].v[1] = 32'h7FC00000; vt[3].v[2] = 32'hC0400000;
    vt[3].v[3] = 32'h3FC00000; vt[3].v[4] = 32'h40000000;
    vt[3].wmask = 10'h01F; vt[3].cls = 4'd4; vt[3].score = 32'h40000000; vt[3].err = 4'b0110;

    for (int i = 0; i < 10; i++) vt[4].v[i] = 32'h7FC00000;
    vt[4].wmask = 10'h3FF; vt[4].cls = 4'd0; vt[4].score = 32'h0; vt[4].err = 4'b0110;

    for (int i = 0; i < 10; i++) vt[5].v[i] = 32'h3F800000;
    vt[5].v[6] = 32'h7F800000; vt[5].v[8] = 32'hFFC00001;
    vt[5].wmask = 10'h3FF; vt[5].cls = 4'd6; vt[5].score = 32'h7F800000; vt[5].err = 4'b0010;

    for (int i = 0; i < 10; i++) vt[6].v[i] = 32'hFF800000;
    vt[6].v[9] = 32'hC0400000;
    vt[6].wmask = 10'h3FF; vt[6].cls = 4'd9; vt[6].score = 32'hC0400000; vt[6].err = 4'b0000;

    for (int i = 0; i < 10; i++) vt[7].v[i] = 32'h40A00000;
    vt[7].wmask = 10'h3FF; vt[7].cls = 4'd0; vt[7].score = 32'h40A00000; vt[7].err = 4'b0000;

    rst = 1'b1; start_i = 1'b0; prcss_done_i = 1'b0;
    y_buf_en_i = 1'b0; y_buf_wr_en_i = 1'b0; y_buf_addr_i = '0; y_buf_data_i = '0;
    result_ready_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, result_valid_o}, 32'd0);
    chk("rst_class", 32'(class_o), 32'd0);
    chk("rst_score", max_score_o, 32'd0);
    chk("rst_err",   32'(err_o), 32'd0);
    chk("rst_done",  {31'd0, done_o}, 32'd0);

    // Table-driven frames, ready held high throughout.
    for (int k = 0; k < NVEC; k++) begin
      result_ready_i = 1'b1;
      pulse_start();
      write_vec(vt[k]);
      if (vt[k].wmask != 10'h3FF) begin
        prcss_done_i = 1'b1;
        tick();
        prcss_done_i = 1'b0;
      end
      wait_valid($sformatf("vec%0d", k));
      chk($sformatf("vec%0d_class", k), 32'(class_o), 32'(vt[k].cls));
      chk($sformatf("vec%0d_score", k), max_score_o, vt[k].score);
      chk($sformatf("vec%0d_err", k), 32'(err_o), 32'(vt[k].err));
      handshake($sformatf("vec%0d", k));
      chk($sformatf("vec%0d_class_kept", k), 32'(class_o), 32'(vt[k].cls));
    end

    // Reset in the middle of COMPARE, then writes without start are ignored.
    pulse_start();
    write_vec(vt[0]);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", {31'd0, result_valid_o}, 32'd0);
    chk("midrst_class", 32'(class_o), 32'd0);
    chk("midrst_score", max_score_o, 32'd0);
    chk("midrst_err",   32'(err_o), 32'd0);
    write_vec(vt[0]);
    wr(6'd2, 32'h7F7FFFFF);
    for (int i = 0; i < 15; i++) tick();
    chk("idle_write_valid", {31'd0, result_valid_o}, 32'd0);
    chk("idle_write_err",   32'(err_o), 32'd0);

    // Bad addresses, rewrite of idx0, then an overrun write while holding.
    pulse_start();
    wr(6'd0, 32'h42480000);
    wr(6'd2, 32'h7F7FFFFF);
    wr(6'd40, 32'h7F7FFFFF);
    write_vec(vt[0]);
    wait_valid("badaddr");
    chk("badaddr_class", 32'(class_o), 32'd9);
    chk("badaddr_score", max_score_o, 32'h41200000);
    chk("badaddr_err",   32'(err_o), 32'b0001);
    wr(6'd0, 32'h7F7FFFFF);
    chk("overrun_err",   32'(err_o), 32'b1001);
    chk("overrun_class", 32'(class_o), 32'd9);
    chk("overrun_score", max_score_o, 32'h41200000);
    chk("overrun_valid", {31'd0, result_valid_o}, 32'd1);
    handshake("overrun");

    // Backpressure for 20 cycles, then abort by start_i during HOLD.
    pulse_start();
    write_vec(vt[6]);
    wait_valid("bp");
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!result_valid_o || done_o || class_o != 4'd9 ||
          max_score_o != 32'hC0400000 || err_o != 4'b0000)
        stable = 1'b0;
    end
    chk("bp_stable", {31'd0, stable}, 32'd1);
    pulse_start();
    chk("abort_valid", {31'd0, result_valid_o}, 32'd0);
    chk("abort_done",  {31'd0, done_o}, 32'd0);
    chk("abort_class", 32'(class_o), 32'd0);
    chk("abort_score", max_score_o, 32'd0);
    write_vec(vt[1]);
    wait_valid("fresh");
    chk("fresh_class", 32'(class_o), 32'd3);
    chk("fresh_score", max_score_o, 32'hBF000000);
    chk("fresh_err",   32'(err_o), 32'd0);
    handshake("fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
